// File: rtl/prco_regfile.sv
// Register file with two registered read ports, one write port, and a busy
// scoreboard bit per register. SP and BP reset to STACK_INIT.
module prco_regfile #(
  parameter int                DATA_W     = 16,
  parameter int                NREGS      = 8,
  parameter int                SEL_W      = 3,
  parameter int                SP_IDX     = 6,
  parameter int                BP_IDX     = 7,
  parameter logic [DATA_W-1:0] STACK_INIT = 16'h00FF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic [SEL_W-1:0]  i_sela,
  output logic [DATA_W-1:0] q_data,
  output logic              q_busya,
  input  logic [SEL_W-1:0]  i_selb,
  output logic [DATA_W-1:0] q_datb,
  output logic              q_busyb,
  input  logic              i_we,
  input  logic [SEL_W-1:0]  i_seld,
  input  logic [DATA_W-1:0] i_datd,
  input  logic              i_claim,
  input  logic [SEL_W-1:0]  i_claim_sel
);

  localparam logic [SEL_W:0] NREGS_W = (SEL_W + 1)'(NREGS);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;

  logic a_ok, b_ok, d_ok, c_ok;
  logic wr, clm;
  logic [DATA_W-1:0] rd_a, rd_b;

  // Selects beyond the implemented registers are treated as absent.
  assign a_ok = {1'b0, i_sela}      < NREGS_W;
  assign b_ok = {1'b0, i_selb}      < NREGS_W;
  assign d_ok = {1'b0, i_seld}      < NREGS_W;
  assign c_ok = {1'b0, i_claim_sel} < NREGS_W;

  assign wr  = i_we    && d_ok;
  assign clm = i_claim && c_ok;

  // Claim is applied after the write's clear so a same-register claim wins.
  // NOTE: always_comb gets a full default first so no latch is inferred.
  always_comb begin
    busy_nxt = busy;
    if (wr)  busy_nxt[i_seld]      = 1'b0;
    if (clm) busy_nxt[i_claim_sel] = 1'b1;
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (a_ok) rd_a = (wr && i_seld == i_sela) ? i_datd : regs[i_sela];
    if (b_ok) rd_b = (wr && i_seld == i_selb) ? i_datd : regs[i_selb];
  end

  // NOTE: the register array itself is reset because SP/BP must come up at
  // STACK_INIT and every other register must read 0 after reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= (i == SP_IDX || i == BP_IDX) ? STACK_INIT : '0;
      busy    <= '0;
      q_data  <= '0;
      q_datb  <= '0;
      q_busya <= 1'b0;
      q_busyb <= 1'b0;
    end else if (i_en) begin
      if (wr) regs[i_seld] <= i_datd;
      busy    <= busy_nxt;
      q_data  <= rd_a;
      q_datb  <= rd_b;
      q_busya <= a_ok ? busy_nxt[i_sela] : 1'b0;
      q_busyb <= b_ok ? busy_nxt[i_selb] : 1'b0;
    end
  end

endmodule

// File: tb/tb_prco_regfile.sv
// Directed bench for prco_regfile: default 8-register instance plus a
// 6-register instance for out-of-range select handling.
module tb_prco_regfile;

  logic        clk = 1'b0;
  logic        reset, en;
  logic [2:0]  sela, selb, seld, claim_sel;
  logic [15:0] datd;
  logic        we, claim;
  logic [15:0] q_data, q_datb;
  logic        q_busya, q_busyb;

  logic [2:0]  sela2, selb2, seld2, claim_sel2;
  logic [15:0] datd2;
  logic        we2, claim2;
  logic [15:0] q_data2, q_datb2;
  logic        q_busya2, q_busyb2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prco_regfile dut (
    .i_clk(clk), .i_reset(reset), .i_en(en),
    .i_sela(sela), .q_data(q_data), .q_busya(q_busya),
    .i_selb(selb), .q_datb(q_datb), .q_busyb(q_busyb),
    .i_we(we), .i_seld(seld), .i_datd(datd),
    .i_claim(claim), .i_claim_sel(claim_sel)
  );

  prco_regfile #(.NREGS(6), .SEL_W(3), .SP_IDX(4), .BP_IDX(5)) dut6 (
    .i_clk(clk), .i_reset(reset), .i_en(en),
    .i_sela(sela2), .q_data(q_data2), .q_busya(q_busya2),
    .i_selb(selb2), .q_datb(q_datb2), .q_busyb(q_busyb2),
    .i_we(we2), .i_seld(seld2), .i_datd(datd2),
    .i_claim(claim2), .i_claim_sel(claim_sel2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge, outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; claim = 1'b0; we2 = 1'b0; claim2 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0;
    sela = 3'd0; selb = 3'd0; seld = 3'd3; datd = 16'h5555; we = 1'b1;
    claim = 1'b1; claim_sel = 3'd3;
    sela2 = 3'd0; selb2 = 3'd0; seld2 = 3'd0; datd2 = 16'h0; we2 = 1'b0;
    claim2 = 1'b0; claim_sel2 = 3'd0;

    // Reset with a concurrent write/claim and en low.
    step(); step();
    check("rst_q_data",  q_data,  16'h0);
    check("rst_q_datb",  q_datb,  16'h0);
    check("rst_q_busya", q_busya, 1'b0);
    check("rst_q_busyb", q_busyb, 1'b0);

    reset = 1'b0; en = 1'b1; idle();
    sela = 3'd6; selb = 3'd7;
    step();
    check("sp_init", q_data,  16'h00FF);
    check("bp_init", q_datb,  16'h00FF);
    check("sp_busy", q_busya, 1'b0);

    for (int i = 0; i < 6; i++) begin
      sela = 3'(i); selb = 3'(i);
      step();
      check($sformatf("r%0d_a_zero", i), q_data, 16'h0);
      check($sformatf("r%0d_b_zero", i), q_datb, 16'h0);
      check($sformatf("r%0d_busy",   i), q_busya, 1'b0);
    end

    // Write-first bypass on port A, port B reads a neighbour.
    we = 1'b1; seld = 3'd3; datd = 16'h1234; sela = 3'd3; selb = 3'd4;
    step();
    check("bypass_a", q_data, 16'h1234);
    check("bypass_b_other", q_datb, 16'h0);
    idle(); sela = 3'd0; selb = 3'd3;
    step();
    check("r3_b_later", q_datb, 16'h1234);

    // Claim is visible in the same cycle's registered busy.
    claim = 1'b1; claim_sel = 3'd2; sela = 3'd2; selb = 3'd2;
    step();
    check("claim_busya", q_busya, 1'b1);
    check("claim_busyb", q_busyb, 1'b1);
    claim = 1'b1; claim_sel = 3'd2;
    step();
    check("reclaim_busy", q_busya, 1'b1);
    idle();
    we = 1'b1; seld = 3'd2; datd = 16'hBEEF;
    step();
    check("r2_write_data", q_data, 16'hBEEF);
    check("r2_write_busy", q_busya, 1'b0);

    // Claim and write same register: data written, claim wins.
    idle();
    we = 1'b1; seld = 3'd5; datd = 16'h0A0A; claim = 1'b1; claim_sel = 3'd5;
    sela = 3'd5; selb = 3'd5;
    step();
    check("cw_data", q_data, 16'h0A0A);
    check("cw_busy", q_busya, 1'b1);
    idle();
    step();
    check("cw_data_held", q_datb, 16'h0A0A);
    check("cw_busy_held", q_busyb, 1'b1);

    // Clock enable low: writes ignored, outputs hold.
    en = 1'b0; we = 1'b1; seld = 3'd1; datd = 16'hFFFF; sela = 3'd1; selb = 3'd6;
    claim = 1'b1; claim_sel = 3'd1;
    step();
    check("en0_hold_a",    q_data,  16'h0A0A);
    check("en0_hold_busy", q_busya, 1'b1);
    check("en0_hold_b",    q_datb,  16'h0A0A);
    en = 1'b1; idle();
    step();
    check("en0_r1_unchanged", q_data,  16'h0);
    check("en0_r1_not_busy",  q_busya, 1'b0);

    // Reset mid-operation with en low, overriding a write/claim of SP.
    reset = 1'b1; en = 1'b0; we = 1'b1; seld = 3'd6; datd = 16'h1111;
    claim = 1'b1; claim_sel = 3'd5;
    step();
    check("rst2_q_data",  q_data,  16'h0);
    check("rst2_q_busyb", q_busyb, 1'b0);
    reset = 1'b0; en = 1'b1; idle(); sela = 3'd6; selb = 3'd5;
    step();
    check("rst2_sp",      q_data,  16'h00FF);
    check("rst2_r5_zero", q_datb,  16'h0);
    check("rst2_r5_busy", q_busyb, 1'b0);

    // Six-register instance: select 7 is absent.
    we2 = 1'b1; seld2 = 3'd7; datd2 = 16'hAAAA; claim2 = 1'b1; claim_sel2 = 3'd7;
    sela2 = 3'd7; selb2 = 3'd4;
    step();
    check("n6_sel7_data", q_data2,  16'h0);
    check("n6_sel7_busy", q_busya2, 1'b0);
    check("n6_sp_init",   q_datb2,  16'h00FF);
    we2 = 1'b1; seld2 = 3'd3; datd2 = 16'hC3C3; claim2 = 1'b0;
    sela2 = 3'd7; selb2 = 3'd3;
    step();
    check("n6_sel7_again", q_data2, 16'h0);
    check("n6_r3_bypass",  q_datb2, 16'hC3C3);
    idle(); sela2 = 3'd7; selb2 = 3'd7;
    step();
    check("n6_sel7_b_data", q_datb2,  16'h0);
    check("n6_sel7_b_busy", q_busyb2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prco_regfile.md
PRCO_REGFILE -- requirements
Module: prco_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter NREGS, default 8, number of registers (2..64).
REQ-003 SHALL have parameter SEL_W, default 3, select width; SEL_W SHALL equal ceil(log2(NREGS)).
REQ-004 SHALL have parameter SP_IDX, default 6, index of the stack-pointer register.
REQ-005 SHALL have parameter BP_IDX, default 7, index of the base-pointer register.
REQ-006 SHALL have parameter STACK_INIT, default 16'h00FF, reset value of SP and BP.
REQ-007 SHALL have port i_clk  in  1  sole clock; all state changes on the rising edge.
REQ-008 SHALL have port i_reset  in  1  reset; synchronous, active-high.
REQ-009 SHALL have port i_en  in  1  clock enable for reads, writes and claims.
REQ-010 SHALL have port i_sela  in  SEL_W  read port A select.
REQ-011 SHALL have port q_data  out  DATA_W  read port A data, registered.
REQ-012 SHALL have port q_busya  out  1  busy flag of the register selected on port A, registered.
REQ-013 SHALL have port i_selb  in  SEL_W  read port B select.
REQ-014 SHALL have port q_datb  out  DATA_W  read port B data, registered.
REQ-015 SHALL have port q_busyb  out  1  busy flag of the register selected on port B, registered.
REQ-016 SHALL have port i_we  in  1  write enable.
REQ-017 SHALL have port i_seld  in  SEL_W  write select.
REQ-018 SHALL have port i_datd  in  DATA_W  write data.
REQ-019 SHALL have port i_claim  in  1  mark a register busy (pending result).
REQ-020 SHALL have port i_claim_sel  in  SEL_W  register to be marked busy.

Function
REQ-021 Read latency SHALL be one cycle: with i_en=1, q_data/q_datb at edge N+1 reflect the selects sampled at edge N.
REQ-022 When i_en=1, i_we=1 and i_seld==i_sela, q_data SHALL take i_datd (write-first bypass); the same rule SHALL apply to port B.
REQ-023 When i_en=1 and i_we=1, reg[i_seld] SHALL take i_datd and busy[i_seld] SHALL clear in the same edge.
REQ-024 When i_en=1 and i_claim=1, busy[i_claim_sel] SHALL set; claiming an already-busy register SHALL leave it busy.
REQ-025 When claim and write hit the same register in one cycle, the data SHALL be written and busy SHALL end set (the claim wins).
REQ-026 q_busya/q_busyb SHALL reflect the busy state after the same edge's write/claim updates, consistent with the bypassed data.
REQ-027 When i_en=0, registers, busy bits and all outputs SHALL hold; i_we and i_claim SHALL be ignored.
REQ-028 A select >= NREGS SHALL read data 0 and busy 0; a write or claim to such a select SHALL be ignored.
REQ-029 Port A and port B SHALL be independent; identical selects SHALL return identical values.
REQ-030 Total state SHALL be NREGS x DATA_W data bits and NREGS busy bits; there is no write-port arbitration (single writer).

Reset
REQ-031 While i_reset=1 at a rising edge, regardless of i_en: all registers SHALL be 0 except reg[SP_IDX] = reg[BP_IDX] = STACK_INIT.
REQ-032 During reset, all busy bits SHALL clear, and q_data, q_datb, q_busya, q_busyb SHALL be 0.
REQ-033 Reset SHALL override a concurrent write or claim, including one issued mid-operation; the first post-reset read of SP SHALL return STACK_INIT.

Verification
REQ-034 Reset, then read sela=6, selb=7 -> next cycle q_data=00FF, q_datb=00FF; reading r0..r5 returns 0000.
REQ-035 Write r3=1234 with sela=3 in the same cycle -> q_data=1234 one cycle later (bypass); a later read of r3 returns 1234.
REQ-036 Claim r2, then read r2 -> q_busya=1; write r2=BEEF -> next read shows q_data=BEEF, q_busya=0.
REQ-037 Claim and write r5=0A0A in one cycle -> reg r5=0A0A, busy r5 remains 1.
REQ-038 i_en=0 with i_we=1 writing r1=FFFF -> r1 unchanged and outputs held; reset asserted with i_en=0 -> SP=00FF, busy all 0.
REQ-039 NREGS=6, SEL_W=3: write to sel=7 is ignored, and a read of sel=7 returns 0 with busy 0.
